// File: rtl/sev_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sev_seg_pkg: shared constants and FSM type for the seven-segment read-back  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sev_seg_pkg;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   localparam logic [4:0] DGT_LEFT  = 5'b01000;
   localparam logic [4:0] DGT_RIGHT = 5'b00001;

   localparam int unsigned CAP_W = 13;

   typedef enum logic [0:0] {
      S_LEFT  = 1'b0,
      S_RIGHT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sev_seg_pattern_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sev_seg_pattern_decoder: 8-bit segment pattern -> {valid, bcd}, comb only.  |
// | SEV_SEG_DP_CHECK_EN: a lit decimal point makes the pattern invalid.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sev_seg_pattern_decoder
   import sev_seg_pkg::*;
(
   input  logic [7:0] seg,
   output logic       valid,
   output logic [3:0] bcd
);

   always_comb begin
      valid = 1'b1;
      bcd   = 4'd0;
      case (seg[6:0])
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: valid = 1'b0;
      endcase
`ifdef SEV_SEG_DP_CHECK_EN
      if (seg[7]) begin
         valid = 1'b0;
      end
`endif
   end

`ifndef SEV_SEG_DP_CHECK_EN
   logic dp_unused;
   assign dp_unused = seg[7];
`endif

endmodule
`default_nettype wire

// File: rtl/sev_seg_bcd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sev_seg_bcd_decoder: stability-filtered seven-segment bus -> BCD pairs.     |
// | SEV_SEG_DP_CHECK_EN (in the pattern decoder) rejects a lit decimal point.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sev_seg_bcd_decoder
   import sev_seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] dgt_slct,
   input  logic [7:0] seg_in,
   output logic [3:0] bcd_out_1,
   output logic [3:0] bcd_out_2,
   output logic       pair_vld,
   output logic       seg_err
);

   localparam logic [3:0] c_stable_cnt = 4'(STABLE_CYCLES);

   logic [CAP_W-1:0] s_q, s_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             acc_q, acc_d;
   state_t           state_q, state_d;
   logic [3:0]       pend_q, pend_d;
   logic [3:0]       bcd1_q, bcd1_d;
   logic [3:0]       bcd2_q, bcd2_d;
   logic             pair_q, pair_d;
   logic             err_q, err_d;

   logic [CAP_W-1:0] cap;
   logic             dec_valid;
   logic [3:0]       dec_bcd;
   logic             is_left;
   logic             is_right;

   // acc_q marks that s_q has just completed its hold; it is acted on one edge
   // later, which gives the E0+STABLE_CYCLES output latency.
   always_comb begin
      cap = {dgt_slct, seg_in};
      s_d = cap;
      if (cap != s_q) begin
         cnt_d = 4'd1;
      end else if (cnt_q < c_stable_cnt) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
      acc_d = (cnt_d == c_stable_cnt) && ((cap != s_q) || (cnt_q != c_stable_cnt));
   end

   sev_seg_pattern_decoder u_pattern_decoder (
      .seg   (s_q[7:0]),
      .valid (dec_valid),
      .bcd   (dec_bcd)
   );

   always_comb begin
      is_left  = (s_q[12:8] == DGT_LEFT);
      is_right = (s_q[12:8] == DGT_RIGHT);
      state_d  = state_q;
      pend_d   = pend_q;
      bcd1_d   = bcd1_q;
      bcd2_d   = bcd2_q;
      pair_d   = 1'b0;
      err_d    = 1'b0;
      if (acc_q && (is_left || is_right)) begin
         case (state_q)
            S_LEFT: begin
               // A pair always opens with a left digit; stray rights are dropped silently.
               if (is_left) begin
                  if (dec_valid) begin
                     pend_d  = dec_bcd;
                     state_d = S_RIGHT;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_RIGHT: begin
               if (!dec_valid) begin
                  err_d   = 1'b1;
                  pend_d  = 4'd0;
                  state_d = S_LEFT;
               end else if (is_left) begin
                  pend_d = dec_bcd;
               end else begin
                  bcd1_d  = pend_q;
                  bcd2_d  = dec_bcd;
                  pair_d  = 1'b1;
                  pend_d  = 4'd0;
                  state_d = S_LEFT;
               end
            end
            default: state_d = S_LEFT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q     <= '0;
         cnt_q   <= 4'd0;
         acc_q   <= 1'b0;
         state_q <= S_LEFT;
         pend_q  <= 4'd0;
         bcd1_q  <= 4'd0;
         bcd2_q  <= 4'd0;
         pair_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         bcd1_q  <= bcd1_d;
         bcd2_q  <= bcd2_d;
         pair_q  <= pair_d;
         err_q   <= err_d;
      end
   end

   assign bcd_out_1 = bcd1_q;
   assign bcd_out_2 = bcd2_q;
   assign pair_vld  = pair_q;
   assign seg_err   = err_q;

endmodule
`default_nettype wire

// File: doc/sev_seg_bcd_decoder.md
# sev_seg_bcd_decoder

Receiving end of the two-digit multiplexed seven-segment bus that the display converter drives. The block samples the digit-select and segment lines, filters them for stability, and decodes each accepted segment pattern back to BCD. It assembles left/right digit pairs and presents each completed pair with a one-cycle strobe. It is used for display read-back, self-check and bench scoreboarding.

## Interface
- STABLE_CYCLES, 1, consecutive identical captures required before a sample is accepted; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dgt_slct  in  5  digit select. 5'b01000 = left digit; 5'b00001 = right digit; any other value = idle.
- seg_in  in  8  segment bus. Bit 0 = a … bit 6 = g, bit 7 = dp. Active high.
- bcd_out_1  out  4  last completed left digit.
- bcd_out_2  out  4  last completed right digit.
- pair_vld  out  1  one-cycle pulse; a new pair was just loaded into bcd_out_1/bcd_out_2.
- seg_err  out  1  one-cycle pulse; an accepted left/right sample held an undecodable pattern.

## Operation
- Capture register s_q <= {dgt_slct, seg_in} on every edge.
- Hold counter:
  - Reset to 1 when the new capture differs from s_q.
  - Otherwise increment, saturating at STABLE_CYCLES.
- Acceptance fires exactly once per held value, on the capture where the count reaches STABLE_CYCLES. A value held longer is not re-accepted.
- Accepted sample with idle dgt_slct (including 0 or multi-hot) is discarded with no error.
- Decode of seg_in[6:0]:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Any other pattern is invalid.
- FSM states: S_LEFT (reset state) and S_RIGHT.
  - S_LEFT + valid left: store in pend_left, go to S_RIGHT.
  - S_LEFT + right digit (valid or invalid): ignored, no error. A pair always starts with left.
  - S_RIGHT + valid left: overwrite pend_left, stay in S_RIGHT.
  - S_RIGHT + valid right: bcd_out_1 <= pend_left, bcd_out_2 <= decoded value, pair_vld = 1, go to S_LEFT.
  - S_RIGHT + invalid left or right: seg_err = 1, drop pend_left, go to S_LEFT.
  - S_LEFT + invalid left: seg_err = 1, stay in S_LEFT.
- bcd_out_1 and bcd_out_2 change only together, in the same cycle as pair_vld.

## Timing
- Reset (rst_n low at an edge):
  - bcd_out_1, bcd_out_2, pair_vld and seg_err are all 0.
  - State is S_LEFT; s_q, hold counter and pend_left are cleared.
- Reset takes priority over every other event, and a reset mid-pair discards the pending left digit.
- Sample latency: a value first captured at edge E0 and held through E0+STABLE_CYCLES−1 updates state and outputs at edge E0+STABLE_CYCLES.
- pair_vld and seg_err are high for exactly one cycle and are never high together.
- With STABLE_CYCLES = 1 the block tracks an encoder that alternates digits every clock: one pair per two clocks.
- A value that changes before reaching STABLE_CYCLES is never accepted.

## Configuration
- SEV_SEG_DP_CHECK_EN defined: an accepted left/right sample with seg_in[7] = 1 is invalid (seg_err, handled as an invalid pattern).
- SEV_SEG_DP_CHECK_EN undefined: seg_in[7] is ignored entirely.

## Structure
- Shared package sev_seg_pkg holds:
  - the ten segment constants SEG_0..SEG_9;
  - DGT_LEFT = 5'b01000 and DGT_RIGHT = 5'b00001;
  - the FSM state typedef.
- Sub-module sev_seg_pattern_decoder: purely combinational. Input is 8-bit seg; outputs are {valid, bcd[3:0]}. It contains the DP-check ifdef.
- Top level holds the capture register, hold counter, FSM and output registers.

## Test plan
- Reset: hold rst_n low 3 cycles with active inputs → all outputs 0; first pair after release decodes correctly.
- STABLE_CYCLES = 1, alternate {01000, 0x5B} and {00001, 0x4F} each clock → pair_vld every 2nd cycle; bcd_out_1 = 2, bcd_out_2 = 3.
- STABLE_CYCLES = 3: left 0x6D held 2 cycles, then 3 cycles; right 0x07 held 4 cycles → only the 3-cycle left is accepted; one pair_vld with 5/7; no repeat during the 4th cycle.
- Left 0x3F, then right 0x49 → seg_err pulse; no pair_vld; outputs keep the previous pair; a following left 0x06 / right 0x7F gives 1/8.
- Right 0x66 first, then left 0x06, left 0x7D, right 0x6F → the first right is ignored; single pair 6/9.
- Left {01000, 0xBF}: with SEV_SEG_DP_CHECK_EN → seg_err; without it → accepted as 0.
